// File: rtl/ans_rans_encoder.sv
// rtl/ans_rans_encoder.sv - rANS encoder: loader table queries, renormalising word output, iterative divide.
`ifndef SYM_WIDTH
`define SYM_WIDTH 2
`endif
`ifndef CNT_WIDTH
`define CNT_WIDTH 9
`endif
`ifndef SYM_COUNT
`define SYM_COUNT 4
`endif

module ans_rans_encoder #(
  parameter int STATE_WIDTH = 16,
  parameter int OUT_WIDTH   = 8,
  parameter int PROB_BITS   = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              en,
  input  logic [`SYM_WIDTH-1:0]             sym_in,
  input  logic                              sym_vld,
  output logic                              sym_rdy,
  input  logic                              flush,
  output logic [1:0]                        ld_read_type,
  output logic [`CNT_WIDTH+`SYM_WIDTH-1:0]  ld_read_query,
  input  logic [`CNT_WIDTH+`SYM_WIDTH-1:0]  ld_read_result,
  input  logic                              ld_read_rdy,
  output logic [OUT_WIDTH-1:0]              out_word,
  output logic                              out_vld,
  input  logic                              out_rdy,
  output logic                              busy,
  output logic                              err
);
  localparam int SW    = STATE_WIDTH;
  localparam int OW    = OUT_WIDTH;
  localparam int CW    = `CNT_WIDTH;
  localparam int YW    = `SYM_WIDTH;
  localparam int QW    = CW + YW;
  localparam int K     = STATE_WIDTH - PROB_BITS;
  localparam int WORDS = SW / OW;
  localparam int CNTW  = $clog2(SW + 1);
  localparam logic [SW-1:0] L_INIT = {{(SW-1){1'b0}}, 1'b1} << (SW - OW);
  localparam logic [QW-1:0] M_TOT  = {{(QW-1){1'b0}}, 1'b1} << PROB_BITS;

  typedef enum logic [3:0] {
    S_IDLE, S_Q_TOT, S_Q_PMF, S_Q_CMF, S_GAP, S_RENORM, S_DIV, S_UPDATE, S_FLUSH
  } state_t;

  state_t          r_state, r_nxt;
  logic            r_sym_rdy, r_out_vld, r_err, r_total_ok;
  logic [1:0]      r_ld_type;
  logic [QW-1:0]   r_ld_query;
  logic [OW-1:0]   r_out_word;
  logic [YW-1:0]   r_sym;
  logic [SW-1:0]   r_x, r_q;
  logic [CW-1:0]   r_f, r_c, r_rem;
  logic [CNTW-1:0] r_cnt;

  logic [SW-1:0]   w_x_sh, w_x_upd;
  logic            w_renorm, w_renorm_sh, w_ge;
  logic [CW:0]     w_rem_sh, w_rem_sub;
  logic [CW-1:0]   w_rem_nx;

  // x >= f << K is evaluated as (x >> K) >= f so the bound never overflows.
  assign w_x_sh      = r_x >> OW;
  assign w_renorm    = {{CW{1'b0}}, r_x >> K} >= {{SW{1'b0}}, r_f};
  assign w_renorm_sh = {{CW{1'b0}}, w_x_sh >> K} >= {{SW{1'b0}}, r_f};

  // Restoring divide step: the borrow bit of the trial subtraction selects the quotient bit.
  assign w_rem_sh  = {r_rem, r_q[SW-1]};
  assign w_rem_sub = w_rem_sh - {1'b0, r_f};
  assign w_ge      = !w_rem_sub[CW];
  assign w_rem_nx  = w_ge ? w_rem_sub[CW-1:0] : w_rem_sh[CW-1:0];
  assign w_x_upd   = (r_q << PROB_BITS) + {{(SW-CW){1'b0}}, r_rem} + {{(SW-CW){1'b0}}, r_c};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_nxt      <= S_IDLE;
      r_sym_rdy  <= 1'b1;
      r_out_vld  <= 1'b0;
      r_err      <= 1'b0;
      r_total_ok <= 1'b0;
      r_ld_type  <= 2'b00;
      r_ld_query <= '0;
      r_out_word <= '0;
      r_sym      <= '0;
      r_x        <= L_INIT;
      r_q        <= '0;
      r_f        <= '0;
      r_c        <= '0;
      r_rem      <= '0;
      r_cnt      <= '0;
    end else if (en) begin
      case (r_state)
        S_IDLE: begin
          if (r_sym_rdy && sym_vld) begin
            r_sym     <= sym_in;
            r_sym_rdy <= 1'b0;
            if (r_total_ok) begin
              r_ld_type  <= 2'b01;
              r_ld_query <= {{(QW-YW){1'b0}}, sym_in};
              r_state    <= S_Q_PMF;
            end else begin
              r_ld_type  <= 2'b10;
              r_ld_query <= QW'(`SYM_COUNT - 1);
              r_state    <= S_Q_TOT;
            end
          end else begin
            if (!sym_vld) r_sym_rdy <= 1'b1;
            if (flush) begin
              r_out_word <= r_x[OW-1:0];
              r_out_vld  <= 1'b1;
              r_cnt      <= '0;
              r_state    <= S_FLUSH;
            end
          end
        end
        S_Q_TOT: begin
          if (ld_read_rdy) begin
            r_ld_type <= 2'b00;
            if (ld_read_result == M_TOT) begin
              r_total_ok <= 1'b1;
              r_nxt      <= S_Q_PMF;
              r_state    <= S_GAP;
            end else begin
              r_err   <= 1'b1;
              r_state <= S_IDLE;
            end
          end
        end
        S_Q_PMF: begin
          if (ld_read_rdy) begin
            r_ld_type <= 2'b00;
            if (ld_read_result == '0) begin
              r_err   <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_f     <= ld_read_result[CW-1:0];
              r_nxt   <= S_Q_CMF;
              r_state <= S_GAP;
            end
          end
        end
        S_GAP: begin
          r_ld_type  <= (r_nxt == S_Q_PMF) ? 2'b01 : 2'b10;
          r_ld_query <= {{(QW-YW){1'b0}}, r_sym};
          r_state    <= r_nxt;
        end
        S_Q_CMF: begin
          if (ld_read_rdy) begin
            r_ld_type <= 2'b00;
            r_c       <= ld_read_result[CW-1:0] - r_f;
            r_state   <= S_RENORM;
          end
        end
        S_RENORM: begin
          if (r_out_vld) begin
            if (out_rdy) begin
              r_x <= w_x_sh;
              if (w_renorm_sh) r_out_word <= w_x_sh[OW-1:0];
              else             r_out_vld  <= 1'b0;
            end
          end else if (w_renorm) begin
            r_out_word <= r_x[OW-1:0];
            r_out_vld  <= 1'b1;
          end else begin
            r_q     <= r_x;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_state <= S_DIV;
          end
        end
        S_DIV: begin
          r_q   <= {r_q[SW-2:0], w_ge};
          r_rem <= w_rem_nx;
          r_cnt <= r_cnt + CNTW'(1);
          if (r_cnt == CNTW'(SW - 1)) r_state <= S_UPDATE;
        end
        S_UPDATE: begin
          r_x     <= w_x_upd;
          r_state <= S_IDLE;
        end
        S_FLUSH: begin
          if (out_rdy) begin
            r_cnt <= r_cnt + CNTW'(1);
            if (r_cnt == CNTW'(WORDS - 1)) begin
              r_out_vld  <= 1'b0;
              r_x        <= L_INIT;
              r_total_ok <= 1'b0;
              r_state    <= S_IDLE;
            end else begin
              r_x        <= w_x_sh;
              r_out_word <= w_x_sh[OW-1:0];
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign sym_rdy       = r_sym_rdy;
  assign ld_read_type  = r_ld_type;
  assign ld_read_query = r_ld_query;
  assign out_word      = r_out_word;
  assign out_vld       = r_out_vld;
  assign busy          = (r_state != S_IDLE);
  assign err           = r_err;
endmodule

// File: tb/tb_ans_rans_encoder.sv
// tb/tb_ans_rans_encoder.sv - scoreboard bench for ans_rans_encoder with a behavioural table loader.
`ifndef SYM_WIDTH
`define SYM_WIDTH 2
`endif
`ifndef CNT_WIDTH
`define CNT_WIDTH 9
`endif
`ifndef SYM_COUNT
`define SYM_COUNT 4
`endif

module tb_ans_rans_encoder;
  logic        clk, rst_n, en;
  logic [1:0]  sym_in;
  logic        sym_vld, sym_rdy, flush;
  logic [1:0]  ld_read_type;
  logic [10:0] ld_read_query, ld_read_result;
  logic        ld_read_rdy;
  logic [7:0]  out_word;
  logic        out_vld, out_rdy, busy, err;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  exp_q[$];
  logic [8:0]  cnt_tab[4];

  ans_rans_encoder #(.STATE_WIDTH(16), .OUT_WIDTH(8), .PROB_BITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .sym_in(sym_in), .sym_vld(sym_vld), .sym_rdy(sym_rdy), .flush(flush),
    .ld_read_type(ld_read_type), .ld_read_query(ld_read_query),
    .ld_read_result(ld_read_result), .ld_read_rdy(ld_read_rdy),
    .out_word(out_word), .out_vld(out_vld), .out_rdy(out_rdy),
    .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] cmf(input int s);
    logic [10:0] acc;
    acc = '0;
    for (int i = 0; i <= s; i++) acc = acc + {2'b00, cnt_tab[i]};
    return acc;
  endfunction

  task automatic set_table(input int a, input int b, input int c, input int d);
    cnt_tab[0] = 9'(a); cnt_tab[1] = 9'(b); cnt_tab[2] = 9'(c); cnt_tab[3] = 9'(d);
  endtask

  // Loader: PMF answers after one cycle, CMF after index+1 cycles, single-cycle rdy pulse.
  initial begin
    int          dly;
    logic [1:0]  idx;
    ld_read_rdy    = 1'b0;
    ld_read_result = '0;
    forever begin
      @(negedge clk);
      if (rst_n && ld_read_type != 2'b00) begin
        idx = ld_read_query[1:0];
        dly = (ld_read_type == 2'b01) ? 1 : int'(idx) + 1;
        repeat (dly - 1) @(negedge clk);
        ld_read_result = (ld_read_type == 2'b01) ? {2'b00, cnt_tab[idx]} : cmf(int'(idx));
        ld_read_rdy = 1'b1;
        @(negedge clk);
        ld_read_rdy = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard on every accepted word and checks hold under backpressure.
  initial begin
    logic       stall;
    logic [7:0] last, e;
    stall = 1'b0;
    last  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) stall = 1'b0;
      else begin
        if (stall) begin
          check("hold_vld", {31'd0, out_vld}, 32'd1);
          check("hold_word", {24'd0, out_word}, {24'd0, last});
        end
        if (out_vld && out_rdy) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_word: got %02h expected none", out_word);
          end else begin
            e = exp_q.pop_front();
            check("out_word", {24'd0, out_word}, {24'd0, e});
          end
        end
        stall = out_vld && !out_rdy;
        last  = out_word;
      end
    end
  end

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while (!(sym_rdy && !busy) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) check({name, "_idle_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic encode(input logic [1:0] s);
    int t;
    @(posedge clk); #1;
    sym_in  = s;
    sym_vld = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (sym_rdy && t < 100);
    if (t >= 100) check("capture_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    sym_vld = 1'b0;
    wait_idle("encode");
  endtask

  task automatic do_flush(input logic [7:0] w0, input logic [7:0] w1);
    int t;
    exp_q.push_back(w0);
    exp_q.push_back(w1);
    @(posedge clk); #1;
    flush = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!busy && t < 100);
    if (t >= 100) check("flush_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    wait_idle("flush");
    repeat (2) @(negedge clk);
    check("drain", exp_q.size(), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int t;
    rst_n = 1'b0; en = 1'b1; sym_in = '0; sym_vld = 1'b0; flush = 1'b0; out_rdy = 1'b1;
    set_table(64, 64, 64, 64);
    repeat (3) @(posedge clk);
    #1;
    check("rst_sym_rdy", {31'd0, sym_rdy}, 32'd1);
    check("rst_ld_type", {30'd0, ld_read_type}, 32'd0);
    check("rst_ld_query", {21'd0, ld_read_query}, 32'd0);
    check("rst_out_word", {24'd0, out_word}, 32'd0);
    check("rst_out_vld", {31'd0, out_vld}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    rst_n = 1'b1;

    // Uniform: 256 -> 1088 -> 4352, flush 0x00 0x11, then x is back at 256.
    encode(2'd1);
    encode(2'd0);
    do_flush(8'h00, 8'h11);
    do_flush(8'h00, 8'h01);
    check("uni_err", {31'd0, err}, 32'd0);

    // Skewed: sym 0 emits 0x00 and returns to 256; sym 3 gives 940 = 0x03AC.
    set_table(1, 85, 85, 85);
    exp_q.push_back(8'h00);
    encode(2'd0);
    encode(2'd3);
    do_flush(8'hAC, 8'h03);

    // Backpressure on the renorm word.
    @(posedge clk); #1 out_rdy = 1'b0;
    exp_q.push_back(8'h00);
    fork
      encode(2'd0);
      begin
        t = 0;
        while (!out_vld && t < 200) begin
          @(negedge clk);
          t++;
        end
        if (t >= 200) check("bp_vld_timeout", 32'd1, 32'd0);
        repeat (5) begin
          @(negedge clk);
          check("bp_vld", {31'd0, out_vld}, 32'd1);
          check("bp_word", {24'd0, out_word}, 32'd0);
        end
        @(posedge clk); #1 out_rdy = 1'b1;
      end
    join
    do_flush(8'h00, 8'h01);

    // Bad total.
    do_reset();
    set_table(64, 64, 64, 63);
    encode(2'd1);
    check("badtot_err", {31'd0, err}, 32'd1);
    check("badtot_sym_rdy", {31'd0, sym_rdy}, 32'd1);
    do_flush(8'h00, 8'h01);

    // Zero frequency then a valid symbol.
    do_reset();
    set_table(0, 128, 64, 64);
    encode(2'd0);
    check("zero_err", {31'd0, err}, 32'd1);
    encode(2'd1);
    check("zero_err_sticky", {31'd0, err}, 32'd1);
    do_flush(8'h00, 8'h02);

    // Reset while dividing.
    do_reset();
    set_table(64, 64, 64, 64);
    @(posedge clk); #1;
    sym_in = 2'd1; sym_vld = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (sym_rdy && t < 100);
    @(posedge clk); #1 sym_vld = 1'b0;
    t = 0;
    while (!(ld_read_rdy && ld_read_type == 2'b10 && ld_read_query == 11'd1) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check("cmf_timeout", 32'd1, 32'd0);
    repeat (4) @(negedge clk);
    check("div_busy_before", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("div_rst_sym_rdy", {31'd0, sym_rdy}, 32'd1);
    check("div_rst_busy", {31'd0, busy}, 32'd0);
    check("div_rst_ld_type", {30'd0, ld_read_type}, 32'd0);
    check("div_rst_ld_query", {21'd0, ld_read_query}, 32'd0);
    check("div_rst_out_vld", {31'd0, out_vld}, 32'd0);
    check("div_rst_err", {31'd0, err}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    encode(2'd1);
    do_flush(8'h40, 8'h04);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
